// File: rtl/keyb_emulator_pkg.sv
// Shared definitions for the keypad emulator: FSM states, one-hot column/row
// constants and the one-hot validity check for key codes.
package keyb_emulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } emu_state_e;

   localparam logic [3:0] COL0 = 4'b0001;
   localparam logic [3:0] COL1 = 4'b0010;
   localparam logic [3:0] COL2 = 4'b0100;
   localparam logic [3:0] COL3 = 4'b1000;
   localparam logic [3:0] ROW0 = 4'b0001;
   localparam logic [3:0] ROW1 = 4'b0010;
   localparam logic [3:0] ROW2 = 4'b0100;
   localparam logic [3:0] ROW3 = 4'b1000;
   localparam logic [7:0] KEY_NONE = 8'h00;

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic key_code_ok(input logic [7:0] k);
      return onehot4(k[7:4]) && onehot4(k[3:0]);
   endfunction

endpackage

// File: rtl/keyb_emulator_fifo.sv
// Synchronous key-code FIFO with full/empty flags; push ignored when full,
// pop ignored when empty.
module keyb_emulator_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) begin
         mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) wr_q <= wr_q + 1'b1;
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/keyb_emulator.sv
// Keypad-side 4x4 matrix emulator: queued key codes are replayed on the row lines,
// aligned to scan frames. Optional bounce prefix via KEYB_EMU_BOUNCE_EN.
//
// state    | meaning
// ST_IDLE  | no key active, waiting for a frame end with a queued code
// ST_PRESS | act_code_q shown on rows while its column is driven
// ST_GAP   | key released for GAP_FRAMES frames before the next one
module keyb_emulator
   import keyb_emulator_pkg::*;
#(
   parameter int HOLD_FRAMES = 4,
   parameter int GAP_FRAMES  = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [3:0] cols_i,
   output logic [3:0] rows_o,
   input  logic       key_valid_i,
   output logic       key_ready_o,
   input  logic [7:0] key_code_i,
   output logic       busy_o,
   output logic       err_code_o
);

`ifdef KEYB_EMU_BOUNCE_EN
   localparam int PRESS_FRAMES = HOLD_FRAMES + 2;
`else
   localparam int PRESS_FRAMES = HOLD_FRAMES;
`endif
   localparam int CW = $clog2(((HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES) + 2);
   localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_FRAMES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_FRAMES - 1);
   localparam logic [CW-1:0] CNT_SAT    = '1;

   emu_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc_d;
   logic [7:0]    act_code_q;
   logic [3:0]    cols_q;
   logic          err_q;

   logic          frame_end;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic          push;
   logic          code_ok;
   logic          pop;
   logic          bounce_off;

   assign frame_end = (cols_i == COL3) && (cols_q != COL3);
   assign push      = key_valid_i && !fifo_full;
   assign code_ok   = key_code_ok(key_code_i);
   assign cnt_inc_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

   assign pop = frame_end && !fifo_empty &&
                ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == GAP_LAST)));

   keyb_emulator_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push && code_ok),
      .data_i  (key_code_i),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         act_code_q <= KEY_NONE;
         cols_q     <= 4'b0000;
         err_q      <= 1'b0;
      end else begin
         cols_q <= cols_i;
         err_q  <= push && !code_ok;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  act_code_q <= fifo_dout;
                  cnt_q      <= '0;
                  state_q    <= ST_PRESS;
               end
            end
            ST_PRESS: begin
               if (frame_end) begin
                  if (cnt_q == PRESS_LAST) begin
                     cnt_q   <= '0;
                     state_q <= ST_GAP;
                  end else begin
                     cnt_q <= cnt_inc_d;
                  end
               end
            end
            ST_GAP: begin
               if (frame_end) begin
                  if (cnt_q == GAP_LAST) begin
                     cnt_q <= '0;
                     if (pop) begin
                        act_code_q <= fifo_dout;
                        state_q    <= ST_PRESS;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_inc_d;
                  end
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Bounce prefix: first press frame asserted, second released, then the hold.
`ifdef KEYB_EMU_BOUNCE_EN
   assign bounce_off = (cnt_q == CW'(1));
`else
   assign bounce_off = 1'b0;
`endif

   // Combinational from live cols so the scanner sees the key on the same edge.
   assign rows_o = ((state_q == ST_PRESS) && (cols_i == act_code_q[7:4]) && !bounce_off) ?
                   act_code_q[3:0] : 4'b0000;

   assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
   assign key_ready_o = !fifo_full;
   assign err_code_o  = err_q;

endmodule
